load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage of the RV32I pipeline. Takes the execute-stage address and store data, runs a request/grant/response handshake with data memory, and stalls the pipeline until the access completes. Produces the aligned, sign- or zero-extended load word that the writeback select consumes as its data-memory input.

## Interface
- TIMEOUT_CYC, 255: maximum cycles spent in REQ+WAIT before the access is aborted with a bus error.
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute stage presents an op; held stable while o_stall=1
- i_mem_read  in  1  load op
- i_mem_write  in  1  store op
- i_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  byte address (ALU result)
- i_store_data  in  32  rs2 value
- o_stall  out  1  freeze upstream stages
- o_load_data  out  32  extended load result to writeback
- o_load_valid  out  1  one-cycle pulse when o_load_data is updated
- o_misaligned  out  1  combinational flag: op rejected for misalignment
- o_bus_err  out  1  one-cycle pulse on timeout
- o_dmem_req  out  1  request valid
- i_dmem_gnt  in  1  request accepted this cycle
- o_dmem_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_dmem_we  out  1  1 = write
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- op = i_valid & (i_mem_read | i_mem_write). If both are set, the op is treated as a read.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- IDLE:
  - op & misaligned: o_misaligned=1 and o_stall=0; no request is issued; state stays IDLE.
  - op & aligned: o_stall=1; latch addr, funct3, we, be, wdata; go to REQ.
- REQ: o_dmem_req=1. All o_dmem_* outputs are registered and held stable until grant.
  - i_dmem_gnt & we: go to DONE.
  - i_dmem_gnt & read: go to WAIT.
- WAIT: on i_dmem_rvalid, register the extracted data into o_load_data and go to DONE. i_dmem_rvalid is ignored outside WAIT.
- DONE: o_stall=0. o_load_valid=1 for loads. Go to IDLE. i_valid is ignored in DONE because it still shows the completed op.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{sd[15:0]}}.
  - SW: be = 1111, wdata = sd.
  - Loads drive be = 1111.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; halfword = rdata[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - funct3 011/110/111 is treated as W.
- Timeout: a counter is cleared on entry to REQ and increments each cycle in REQ/WAIT. At TIMEOUT_CYC, go to DONE with o_bus_err=1, o_load_valid=0, o_dmem_req dropped, and o_load_data unchanged.

## Timing
- o_stall is combinational in IDLE (op & aligned); it is 1 in REQ and WAIT and 0 in DONE.
- Store, grant in first REQ cycle: o_stall high for 2 cycles (IDLE accept, REQ); DONE is the 3rd cycle.
- Load, grant in first REQ cycle and rvalid on the next cycle: o_stall high for 3 cycles; o_load_valid pulses in the 4th cycle.
- Each grant wait or rvalid wait adds exactly one stall cycle per cycle of delay.
- o_load_data holds its value until the next successful load.
- Back-to-back ops: the next op is accepted in the IDLE cycle immediately after DONE. Throughput is at most one access per 3 cycles.
- Reset (asynchronous, any state): state=IDLE. o_dmem_req, o_dmem_we, o_load_valid, o_bus_err, o_stall, o_misaligned = 0. o_dmem_be, o_dmem_addr, o_dmem_wdata, o_load_data and the counter = 0. An in-flight request is dropped immediately.

## Test plan
- SB, addr=0x1003, sd=0x000000AB, immediate grant -> be=1000, wdata=0xABABABAB, addr=0x1000; stall exactly 2 cycles.
- LB, addr=0x2001, rdata=0x00008000, rvalid 1 cycle after grant -> o_load_data=0xFFFFFF80 and o_load_valid pulses in cycle 4. Repeat as LBU -> 0x00000080.
- LH, addr=0x2002, rdata=0x80010000, grant delayed 3 cycles -> o_load_data=0xFFFF8001; stall lasts 6 cycles.
- LW, addr=0x3002 -> o_misaligned=1 the same cycle, o_dmem_req never asserts, o_stall=0.
- LW with grant but no rvalid, TIMEOUT_CYC=8 -> o_bus_err pulses once, o_load_valid=0, FSM returns to IDLE.
- Assert i_rst_n=0 while in WAIT -> o_dmem_req and o_stall drop asynchronously; after release, a fresh SW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: req/gnt/rvalid handshake with data memory, store lane
// steering, load extraction/extension, pipeline stall and bus-error timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    input  logic        i_dmem_gnt,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_we,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, wdata_q, load_data_q;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic [3:0]      be_q;
    logic            we_q, err_q;

    logic            op, is_write, misaligned, accept, timeout, abort, load_upd, sext;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new, load_ext;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Read wins when both read and write are requested.
    assign op         = i_valid & (i_mem_read | i_mem_write);
    assign is_write   = i_mem_write & ~i_mem_read;
    assign misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                        (i_funct3[1] & (i_addr[1:0] != 2'b00));
    assign accept     = (state_q == StIdle) & op & ~misaligned;
    assign timeout    = (cnt_q == CntLast);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_store_data;
        if (is_write) begin
            case (i_funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << i_addr[1:0];
                    wdata_new = {4{i_store_data[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << {i_addr[1], 1'b0};
                    wdata_new = {2{i_store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = i_dmem_rdata[{off_q, 3'b000} +: 8];
        half_sel = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];
        sext     = ~funct3_q[2];
        load_ext = i_dmem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sext & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort    = 1'b0;
        load_upd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (i_dmem_gnt) begin
                    state_d = we_q ? StDone : StWait;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (i_dmem_rvalid) begin
                    load_upd = 1'b1;
                    state_d  = StDone;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            StDone: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Only set on the abort transition, so it is high exactly in DONE.
            err_q   <= abort;
            if (accept) begin
                addr_q   <= {i_addr[31:2], 2'b00};
                off_q    <= i_addr[1:0];
                funct3_q <= i_funct3;
                we_q     <= is_write;
                be_q     <= be_new;
                wdata_q  <= wdata_new;
            end
            if (load_upd) begin
                load_data_q <= load_ext;
            end
        end
    end

    // Combinational handshake flags are masked while reset is asserted.
    assign o_stall      = i_rst_n & (accept | (state_q == StReq) | (state_q == StWait));
    assign o_misaligned = i_rst_n & (state_q == StIdle) & op & misaligned;
    assign o_load_valid = (state_q == StDone) & ~we_q & ~err_q;
    assign o_bus_err    = err_q;
    assign o_load_data  = load_data_q;
    assign o_dmem_req   = (state_q == StReq);
    assign o_dmem_addr  = addr_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized ops checked against a
// byte-arithmetic model of lane steering, extension, latency and timeout.
module tb_load_store_unit;
    localparam int unsigned TO = 8;

    logic        i_clk, i_rst_n, i_valid, i_mem_read, i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_store_data;
    logic        o_stall, o_load_valid, o_misaligned, o_bus_err;
    logic [31:0] o_load_data;
    logic        o_dmem_req, i_dmem_gnt, o_dmem_we, i_dmem_rvalid;
    logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [3:0]  o_dmem_be;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr),
        .i_store_data(i_store_data), .o_stall(o_stall), .o_load_data(o_load_data),
        .o_load_valid(o_load_valid), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_addr(o_dmem_addr),
        .o_dmem_we(o_dmem_we), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_ld = 32'h0;

    // Observations gathered by run_op for the calling test.
    int          obs_stall, obs_lv, obs_lv_cyc, obs_err;
    bit          obs_mis, obs_req, obs_unstable, obs_hung;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    logic        obs_we;

    // ---------------- reference model ----------------
    function automatic int size_f(input logic [2:0] f3);
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    function automatic bit mis_f(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_f(f3)) != 0;
    endfunction

    function automatic logic [3:0] be_f(input bit wr, input logic [2:0] f3,
                                        input logic [31:0] a);
        int sz = size_f(f3);
        if (!wr) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wdata_f(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] b, h;
        b = sd & 32'hFF;
        h = sd & 32'hFFFF;
        if (size_f(f3) == 1) return b * 32'h01010101;
        if (size_f(f3) == 2) return h * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdw);
        longint sz, v, lim;
        sz = size_f(f3);
        if (sz == 4) return rdw;
        lim = longint'(1) << (8 * sz);
        v = (longint'({32'b0, rdw}) >> (8 * (a % 4))) % lim;
        if (f3 < 4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    // ---------------- stimulus driver / memory responder ----------------
    // Entered just after a rising edge; returns just after the edge following completion.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdw, input int gd, input int rvd,
                          input bit spur);
        int  req_n = 0;
        int  wait_n = 0;
        bit  granted = 0;
        obs_stall = 0; obs_lv = 0; obs_lv_cyc = 0; obs_err = 0;
        obs_mis = 0; obs_req = 0; obs_unstable = 0; obs_hung = 1;
        obs_addr = 'x; obs_wdata = 'x; obs_be = 'x; obs_we = 1'bx; obs_ld = 'x;
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
        i_addr = a; i_store_data = sd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge i_clk);
            if (o_stall) obs_stall++;
            if (o_load_valid) begin obs_lv++; obs_lv_cyc = cyc; end
            if (o_bus_err) obs_err++;
            if (o_misaligned) obs_mis = 1;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = $urandom;
            if (o_dmem_req) begin
                if (!obs_req) begin
                    obs_addr = o_dmem_addr; obs_wdata = o_dmem_wdata;
                    obs_be = o_dmem_be; obs_we = o_dmem_we;
                end else if (obs_addr !== o_dmem_addr || obs_wdata !== o_dmem_wdata ||
                             obs_be !== o_dmem_be || obs_we !== o_dmem_we) begin
                    obs_unstable = 1;
                end
                obs_req = 1;
                i_dmem_gnt = (req_n >= gd);
                i_dmem_rvalid = spur;
                req_n++;
                if (i_dmem_gnt) granted = 1;
            end else if (granted && rd && o_stall) begin
                if (wait_n >= rvd) begin
                    i_dmem_rvalid = 1'b1;
                    i_dmem_rdata = rdw;
                end
                wait_n++;
            end
            if (!o_stall) begin
                obs_ld = o_load_data;
                obs_hung = 0;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
        if (obs_hung) begin
            checks++; failures++;
            $display("FAIL op_timeout: op a=%h never released stall within 40 cycles", a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        i_rst_n = 1'b0; i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_funct3 = 3'b010; i_addr = 32'h100; i_store_data = 32'h0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        #2;
        checks++;
        if ({o_stall, o_dmem_req, o_dmem_we, o_load_valid, o_bus_err, o_misaligned} !== 6'b0)
        begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000",
                     {o_stall, o_dmem_req, o_dmem_we, o_load_valid, o_bus_err, o_misaligned});
        end
        checks++;
        if ({o_dmem_addr, o_dmem_wdata, o_load_data, o_dmem_be} !== 100'b0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h ld=%h be=%b want all zero",
                     o_dmem_addr, o_dmem_wdata, o_load_data, o_dmem_be);
        end
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic test_store_byte;
        run_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 0, 0, 1'b0);
        checks++;
        if (obs_be !== 4'b1000) begin
            failures++; $display("FAIL sb_be got=%b want=1000", obs_be);
        end
        checks++;
        if (obs_wdata !== 32'hABABABAB || obs_addr !== 32'h1000 || obs_we !== 1'b1) begin
            failures++;
            $display("FAIL sb_bus got wdata=%h addr=%h we=%b want ABABABAB 00001000 1",
                     obs_wdata, obs_addr, obs_we);
        end
        checks++;
        if (obs_stall != 2) begin
            failures++; $display("FAIL sb_stall got=%0d want=2", obs_stall);
        end
    endtask

    task automatic test_load_byte;
        run_op(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h00008000, 0, 0, 1'b0);
        model_ld = 32'hFFFFFF80;
        checks++;
        if (obs_ld !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lb_data got=%h want=ffffff80", obs_ld);
        end
        checks++;
        if (obs_lv != 1 || obs_lv_cyc != 4 || obs_stall != 3) begin
            failures++;
            $display("FAIL lb_timing got lv=%0d cyc=%0d stall=%0d want 1 4 3",
                     obs_lv, obs_lv_cyc, obs_stall);
        end
        run_op(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h00008000, 0, 0, 1'b0);
        model_ld = 32'h00000080;
        checks++;
        if (obs_ld !== 32'h00000080) begin
            failures++; $display("FAIL lbu_data got=%h want=00000080", obs_ld);
        end
    endtask

    task automatic test_load_half_delay;
        run_op(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'h80010000, 3, 0, 1'b1);
        model_ld = 32'hFFFF8001;
        checks++;
        if (obs_ld !== 32'hFFFF8001) begin
            failures++; $display("FAIL lh_data got=%h want=ffff8001", obs_ld);
        end
        checks++;
        if (obs_stall != 6 || obs_unstable) begin
            failures++;
            $display("FAIL lh_stall got stall=%0d unstable=%0d want 6 0",
                     obs_stall, obs_unstable);
        end
    endtask

    task automatic test_misaligned;
        run_op(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 1'b0);
        checks++;
        if (!obs_mis || obs_req || obs_stall != 0) begin
            failures++;
            $display("FAIL lw_misaligned got mis=%0d req=%0d stall=%0d want 1 0 0",
                     obs_mis, obs_req, obs_stall);
        end
    endtask

    task automatic test_timeout;
        run_op(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'h12345678, 0, 1000, 1'b0);
        checks++;
        if (obs_err != 1 || obs_lv != 0) begin
            failures++;
            $display("FAIL timeout_err got err=%0d lv=%0d want 1 0", obs_err, obs_lv);
        end
        checks++;
        if (obs_stall != int'(TO) + 1 || obs_ld !== model_ld) begin
            failures++;
            $display("FAIL timeout_stall got stall=%0d ld=%h want %0d %h",
                     obs_stall, obs_ld, TO + 1, model_ld);
        end
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 1'b1, 3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 0, 0, 1'b0);
        run_op(1'b1, 1'b0, 3'b101, 32'h4006, 32'h0, 32'h9ABC1234, 0, 0, 1'b0);
        model_ld = 32'h00009ABC;
        checks++;
        if (obs_stall != 3 || obs_ld !== 32'h00009ABC) begin
            failures++;
            $display("FAIL b2b_lhu got stall=%0d ld=%h want 3 00009abc", obs_stall, obs_ld);
        end
    endtask

    task automatic test_reset_inflight;
        logic [31:0] sd;
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_funct3 = 3'b010; i_addr = 32'h5000;
        @(negedge i_clk);                 // IDLE accept
        @(negedge i_clk);                 // REQ
        i_dmem_gnt = o_dmem_req;
        @(negedge i_clk);                 // WAIT
        i_dmem_gnt = 1'b0;
        checks++;
        if (o_stall !== 1'b1) begin
            failures++; $display("FAIL rst_wait_pre got stall=%b want 1", o_stall);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_stall !== 1'b0 || o_dmem_req !== 1'b0 || o_load_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_async got stall=%b req=%b ld=%h want 0 0 0",
                     o_stall, o_dmem_req, o_load_data);
        end
        model_ld = 32'h0;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        sd = $urandom;
        run_op(1'b0, 1'b1, 3'b010, 32'h5004, sd, 32'h0, 1, 0, 1'b0);
        checks++;
        if (obs_be !== 4'hF || obs_wdata !== sd || obs_addr !== 32'h5004 || obs_stall != 3)
        begin
            failures++;
            $display("FAIL rst_sw got be=%b wdata=%h addr=%h stall=%0d want 1111 %h 00005004 3",
                     obs_be, obs_wdata, obs_addr, obs_stall, sd);
        end
    endtask

    task automatic test_random(input int n);
        bit          rd, wr, mis, tmo;
        logic [2:0]  f3;
        logic [31:0] a, sd, rdw;
        int          gd, rvd, rw, exp_stall;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 2))
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sd  = $urandom;
            rdw = $urandom;
            gd  = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 2);
            rvd = $urandom_range(0, 2);
            run_op(rd, wr, f3, a, sd, rdw, gd, rvd, 1'($urandom_range(0, 1)));
            mis = mis_f(f3, a);
            rw  = (gd + 1) + (rd ? rvd + 1 : 0);
            tmo = !mis && rw > int'(TO);
            if (tmo) rw = TO;
            exp_stall = mis ? 0 : 1 + rw;
            if (!mis && rd && !tmo) model_ld = load_f(f3, a, rdw);
            checks++;
            if (obs_stall != exp_stall || obs_mis != mis || obs_req != !mis) begin
                failures++;
                $display("FAIL rnd_ctrl op%0d got stall=%0d mis=%0d req=%0d want %0d %0d %0d",
                         k, obs_stall, obs_mis, obs_req, exp_stall, mis, !mis);
            end
            checks++;
            if (obs_lv != int'(!mis && rd && !tmo) || obs_err != int'(tmo)) begin
                failures++;
                $display("FAIL rnd_pulse op%0d got lv=%0d err=%0d want %0d %0d",
                         k, obs_lv, obs_err, !mis && rd && !tmo, tmo);
            end
            checks++;
            if (obs_ld !== model_ld) begin
                failures++;
                $display("FAIL rnd_load op%0d f3=%b a=%h rd=%h got=%h want=%h",
                         k, f3, a, rdw, obs_ld, model_ld);
            end
            if (!mis) begin
                checks++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_we !== (wr && !rd) ||
                    obs_be !== be_f(wr && !rd, f3, a) || obs_unstable ||
                    (wr && !rd && obs_wdata !== wdata_f(f3, sd))) begin
                    failures++;
                    $display("FAIL rnd_bus op%0d got addr=%h we=%b be=%b wd=%h uns=%0d want %h %b %b %h",
                             k, obs_addr, obs_we, obs_be, obs_wdata, obs_unstable,
                             {a[31:2], 2'b00}, wr && !rd, be_f(wr && !rd, f3, a),
                             wdata_f(f3, sd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half_delay();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_inflight();
        test_random(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
